// File: rtl/payload_engine_pkg.sv
// payload_engine_pkg: class count, class-definition table, class indices and decoder FSM states
package payload_engine_pkg;

    localparam int NUM_CLASSES = 66;

    localparam int CLS_LOWER  = 0;
    localparam int CLS_UPPER  = 26;
    localparam int CLS_DIGIT0 = 52;
    localparam int CLS_QMARK  = 62;
    localparam int CLS_EQUALS = 63;
    localparam int CLS_DIGIT  = 64;
    localparam int CLS_ANY    = 65;

    typedef enum logic [1:0] {IDLE, SOD, BYTES, EOD} state_t;

    function automatic logic [255:0] class_mask(input int c);
        logic [255:0] m;
        m = '0;
        if (c < CLS_UPPER) m[8'(8'h61 + c - CLS_LOWER)] = 1'b1;
        else if (c < CLS_DIGIT0) m[8'(8'h41 + c - CLS_UPPER)] = 1'b1;
        else if (c < CLS_QMARK) m[8'(8'h30 + c - CLS_DIGIT0)] = 1'b1;
        else if (c == CLS_QMARK) m[8'h3f] = 1'b1;
        else if (c == CLS_EQUALS) m[8'h3d] = 1'b1;
        else if (c == CLS_DIGIT) m[8'h39:8'h30] = '1;
        else m = '1;
        return m;
    endfunction

    // lanes in use: everything below the first cleared keep bit
    function automatic logic [3:0] keep_len(input logic [7:0] k);
        logic [3:0] n;
        n = 4'd8;
        for (int i = 7; i >= 0; i--) if (!k[i]) n = 4'(i);
        return n;
    endfunction

endpackage

// File: rtl/char_class_lut.sv
// char_class_lut: byte -> class membership vector; CHAR_DECODER_NOCASE_EN folds A-Z to a-z first
module char_class_lut import payload_engine_pkg::*; (
    input  logic [7:0]             ch,
    output logic [NUM_CLASSES-1:0] char_class
);

    logic [7:0] key;

`ifdef CHAR_DECODER_NOCASE_EN
    assign key = (ch >= 8'h41 && ch <= 8'h5a) ? (ch | 8'h20) : ch;
`else
    assign key = ch;
`endif

    genvar n;
    for (n = 0; n < NUM_CLASSES; n++) begin : g_cls
        localparam logic [255:0] MASK = class_mask(n);
        assign char_class[n] = MASK[key];
    end

endmodule

// File: rtl/payload_char_decoder.sv
// payload_char_decoder: serializes 64-bit payload beats to bytes and decodes character classes
// Optional CHAR_DECODER_NOCASE_EN (inside char_class_lut) makes class lookup case-insensitive.
module payload_char_decoder import payload_engine_pkg::*; #(
    parameter int LEN_W = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [63:0]            s_tdata,
    input  logic [7:0]             s_tkeep,
    input  logic                   s_tlast,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [NUM_CLASSES-1:0] char_class,
    output logic                   en,
    output logic                   sod,
    output logic                   eod,
    output logic [LEN_W-1:0]       pkt_len
);

    state_t                 state, state_d;
    logic [63:0]            buf_data;
    logic [3:0]             buf_len, ptr, ptr_d;
    logic                   buf_last, hs, load, emit;
    logic [7:0]             ch;
    logic [NUM_CLASSES-1:0] cls;

    // ptr counts bytes of the buffered beat already emitted; ptr==buf_len means drained
    assign s_tready = resetn && (state == IDLE || (state == BYTES && !buf_last && ptr == buf_len));
    assign hs = s_tvalid && s_tready;

    always_comb begin
        state_d = state;
        ptr_d = ptr;
        load = 1'b0;
        emit = 1'b0;
        ch = buf_data[{ptr[2:0], 3'b000} +: 8];
        case (state)
            IDLE: begin
                load = hs;
                state_d = hs ? SOD : IDLE;
                ptr_d = 4'd0;
            end
            SOD: begin
                emit = buf_len != 4'd0;
                ptr_d = {3'b000, emit};
                state_d = (buf_len == 4'd0 && buf_last) ? EOD : BYTES;
            end
            BYTES: begin
                if (ptr != buf_len) begin
                    emit = 1'b1;
                    ptr_d = ptr + 4'd1;
                end else if (buf_last) begin
                    state_d = EOD;
                end else if (hs) begin
                    // refill straight from the bus so the stream has no bubble
                    load = 1'b1;
                    ch = s_tdata[7:0];
                    emit = keep_len(s_tkeep) != 4'd0;
                    ptr_d = {3'b000, emit};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    char_class_lut u_lut (.ch(ch), .char_class(cls));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            ptr <= 4'd0;
            buf_data <= '0;
            buf_len <= 4'd0;
            buf_last <= 1'b0;
            char_class <= '0;
            en <= 1'b0;
            sod <= 1'b0;
            eod <= 1'b0;
            pkt_len <= '0;
        end else begin
            state <= state_d;
            ptr <= ptr_d;
            if (load) begin
                buf_data <= s_tdata;
                buf_len <= keep_len(s_tkeep);
                buf_last <= s_tlast;
            end
            en <= emit;
            char_class <= emit ? cls : '0;
            sod <= state_d == SOD;
            eod <= state_d == EOD;
            if (state_d == SOD) pkt_len <= '0;
            else if (emit && pkt_len != '1) pkt_len <= pkt_len + 1'b1;
        end
    end

endmodule
